// File: rtl/riscv_core_demux1x4_reg_pkg.sv
// Shared types and lane constants for the registered 1:4 demux.
// Optional build macro: RISCV_CORE_DEMUX_DATA_GATE_EN (see top).
package riscv_core_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      BUSY,
      FULL
   } riscv_core_demux_state_e;

   localparam int DEMUX_LANES = 4;

   localparam logic [1:0] LANE_ALU = 2'd0;
   localparam logic [1:0] LANE_MUL = 2'd1;
   localparam logic [1:0] LANE_DIV = 2'd2;
   localparam logic [1:0] LANE_LSU = 2'd3;

endpackage

// File: rtl/riscv_core_demux1x4_reg_if.sv
// Producer/consumer bundle of the 1:4 demux.
// slave = demux side, master = the environment driving it.
interface riscv_core_demux1x4_reg_if #(
   parameter int XLEN = 32
);
   import riscv_core_pkg::*;

   logic                   i_demux_flush;
   logic                   i_demux_valid;
   logic [XLEN-1:0]        i_demux_data;
   logic [1:0]             i_demux_sel;
   logic                   o_demux_ready;
   logic [DEMUX_LANES-1:0] o_demux_valid;
   logic [XLEN-1:0]        o_demux_data;
   logic [1:0]             o_demux_sel;
   logic [DEMUX_LANES-1:0] i_demux_ready;

   modport slave (
      input  i_demux_flush,
      input  i_demux_valid,
      input  i_demux_data,
      input  i_demux_sel,
      output o_demux_ready,
      output o_demux_valid,
      output o_demux_data,
      output o_demux_sel,
      input  i_demux_ready
   );

   modport master (
      output i_demux_flush,
      output i_demux_valid,
      output i_demux_data,
      output i_demux_sel,
      input  o_demux_ready,
      input  o_demux_valid,
      input  o_demux_data,
      input  o_demux_sel,
      output i_demux_ready
   );

endinterface

// File: rtl/riscv_core_demux1x4_reg_dec2to4.sv
// 2-to-4 one-hot decoder with enable.
// Drives the per-lane valids from the held lane index.
module riscv_core_dec2to4
   import riscv_core_pkg::*;
(
   input  logic                   i_en,
   input  logic [1:0]             i_sel,
   output logic [DEMUX_LANES-1:0] o_onehot
);

   // One bit set for the selected lane, none when disabled
   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         o_onehot[i_sel] = 1'b1;
      end
   end

endmodule

// File: rtl/riscv_core_demux1x4_reg.sv
// Registered 1:4 demux: main register plus one skid entry.
// RISCV_CORE_DEMUX_DATA_GATE_EN zeroes data/sel while idle.
module riscv_core_demux1x4_reg
   import riscv_core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   riscv_core_demux1x4_reg_if.slave      bus
);

   riscv_core_demux_state_e state_q, state_d;
   logic [XLEN-1:0]         main_data_q, main_data_d;
   logic [1:0]              main_sel_q, main_sel_d;
   logic [XLEN-1:0]         skid_data_q, skid_data_d;
   logic [1:0]              skid_sel_q, skid_sel_d;
   logic                    ready_q, ready_d;

   logic                    main_full;
   logic                    in_fire;
   logic                    out_fire;
   logic [DEMUX_LANES-1:0]  lane_valid;

   assign main_full = (state_q != EMPTY);
   assign in_fire   = bus.i_demux_valid & ready_q;
   assign out_fire  = main_full & bus.i_demux_ready[main_sel_q];

   // Next-state, main register and skid entry updates
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_sel_d  = main_sel_q;
      skid_data_d = skid_data_q;
      skid_sel_d  = skid_sel_q;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_data_d = bus.i_demux_data;
               main_sel_d  = bus.i_demux_sel;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               main_data_d = bus.i_demux_data;
               main_sel_d  = bus.i_demux_sel;
            end else if (in_fire) begin
               skid_data_d = bus.i_demux_data;
               skid_sel_d  = bus.i_demux_sel;
               state_d     = FULL;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_data_d = skid_data_q;
               main_sel_d  = skid_sel_q;
               skid_data_d = '0;
               skid_sel_d  = '0;
               state_d     = BUSY;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (bus.i_demux_flush) begin
         state_d     = EMPTY;
         main_data_d = main_data_q;
         main_sel_d  = main_sel_q;
         skid_data_d = '0;
         skid_sel_d  = '0;
      end
      ready_d = (state_d != FULL);
   end

   // State and payload registers, cleared by async reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_sel_q  <= '0;
         skid_data_q <= '0;
         skid_sel_q  <= '0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_sel_q  <= main_sel_d;
         skid_data_q <= skid_data_d;
         skid_sel_q  <= skid_sel_d;
         ready_q     <= ready_d;
      end
   end

   riscv_core_dec2to4 u_dec (
      .i_en     (main_full),
      .i_sel    (main_sel_q),
      .o_onehot (lane_valid)
   );

   assign bus.o_demux_valid = lane_valid;
   assign bus.o_demux_ready = ready_q;

`ifdef RISCV_CORE_DEMUX_DATA_GATE_EN
   assign bus.o_demux_data = main_full ? main_data_q : '0;
   assign bus.o_demux_sel  = main_full ? main_sel_q : 2'b00;
`else
   assign bus.o_demux_data = main_data_q;
   assign bus.o_demux_sel  = main_sel_q;
`endif

endmodule
